dca_matrix_lsu_rdata_assembler: RTL

- Load-path stage that collects AXI read-data beats into one full memory row buffer per row descriptor.
- Presents the row, with its opaque transaction info, to the downstream element-unpack stage.
- The unpack stage sign/zero-extends the packed elements.
- Sits between the LSU AXI R channel / per-row descriptor FIFO and that unpacker. Handles beat placement, beat counting, row hand-off and back-pressure.

---
 rtl/dca_matrix_lsu_rdata_assembler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dca_matrix_lsu_rdata_assembler.sv
// ============================================================================
// Module      : dca_matrix_lsu_rdata_assembler
// Description : Packs AXI read-data beats into one row buffer per row
//               descriptor and hands the tagged row to the unpack stage.
//               Optional rlast checking: DCA_RDATA_ASSEMBLER_RLAST_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dca_matrix_lsu_rdata_assembler #(
    parameter int BW_AXI_DATA    = 32,
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_TXN_INFO    = 16,
    localparam int BW_ROW        = 32 * MATRIX_NUM_COL,
    localparam int MAX_BEAT      = BW_ROW / BW_AXI_DATA,
    localparam int BW_BEAT       = (MAX_BEAT > 1) ? $clog2(MAX_BEAT) : 1
) (
    input  logic                   clk,
    input  logic                   rstnn,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [BW_BEAT-1:0]     desc_num_beat_m1,
    input  logic [BW_TXN_INFO-1:0] desc_txn_info,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [BW_AXI_DATA-1:0] rdata,
    input  logic                   rlast,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [BW_ROW-1:0]      row_data,
    output logic [BW_TXN_INFO-1:0] row_txn_info
`ifdef DCA_RDATA_ASSEMBLER_RLAST_CHECK_EN
    ,
    output logic                   err_rlast,
    input  logic                   err_clear,
    output logic                   row_rlast_ok
`endif
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_HOLD    = 2'd2;

    logic [1:0]             r_state;
    logic [BW_BEAT-1:0]     r_beat_cnt;
    logic [BW_BEAT-1:0]     r_num_m1;
    logic [BW_ROW-1:0]      r_row;
    logic [BW_TXN_INFO-1:0] r_txn;

    logic                   w_active;
    logic                   w_desc_hs;
    logic                   w_r_hs;
    logic                   w_row_hs;
    logic                   w_last_beat;
    logic [BW_BEAT-1:0]     w_num_m1;

    // Reset and clear also suppress every handshake offered in their cycle.
    assign w_active    = enable & rstnn & ~clear;
    assign desc_ready  = w_active & ((r_state == c_IDLE) | ((r_state == c_HOLD) & row_ready));
    assign rready      = w_active & (r_state == c_COLLECT);
    assign row_valid   = w_active & (r_state == c_HOLD);
    assign row_data    = r_row;
    assign row_txn_info = r_txn;

    assign w_desc_hs   = desc_valid & desc_ready;
    assign w_r_hs      = rvalid & rready;
    assign w_row_hs    = row_valid & row_ready;
    assign w_last_beat = (r_beat_cnt == r_num_m1);

    // Clamping is only needed when the counter can encode more than MAX_BEAT.
    generate
        if ((1 << BW_BEAT) > MAX_BEAT) begin : g_clamp
            localparam logic [BW_BEAT-1:0] c_MAX_M1 = BW_BEAT'(MAX_BEAT - 1);
            assign w_num_m1 = (desc_num_beat_m1 > c_MAX_M1) ? c_MAX_M1 : desc_num_beat_m1;
        end else begin : g_no_clamp
            assign w_num_m1 = desc_num_beat_m1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            r_state    <= c_IDLE;
            r_beat_cnt <= '0;
            r_num_m1   <= '0;
            r_row      <= '0;
            r_txn      <= '0;
        end else begin
            if (w_desc_hs) begin
                r_state    <= c_COLLECT;
                r_txn      <= desc_txn_info;
                r_num_m1   <= w_num_m1;
                r_row      <= '0;
                r_beat_cnt <= '0;
            end else if (w_row_hs) begin
                r_state <= c_IDLE;
            end
            if (w_r_hs) begin
                for (int i = 0; i < MAX_BEAT; i++) begin
                    if (r_beat_cnt == BW_BEAT'(i)) begin
                        r_row[i*BW_AXI_DATA +: BW_AXI_DATA] <= rdata;
                    end
                end
                if (w_last_beat) begin
                    r_beat_cnt <= '0;
                    r_state    <= c_HOLD;
                end else begin
                    r_beat_cnt <= r_beat_cnt + BW_BEAT'(1);
                end
            end
        end
    end

`ifdef DCA_RDATA_ASSEMBLER_RLAST_CHECK_EN
    logic r_err_rlast;
    logic r_row_ok;
    logic w_beat_bad;

    // rlast must be low on every beat but the counted final one.
    assign w_beat_bad   = w_r_hs & (rlast != w_last_beat);
    assign err_rlast    = r_err_rlast;
    assign row_rlast_ok = row_valid & r_row_ok;

    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            r_err_rlast <= 1'b0;
            r_row_ok    <= 1'b0;
        end else begin
            if (w_beat_bad) begin
                r_err_rlast <= 1'b1;
            end else if (err_clear) begin
                r_err_rlast <= 1'b0;
            end
            if (w_desc_hs) begin
                r_row_ok <= 1'b1;
            end else if (w_beat_bad) begin
                r_row_ok <= 1'b0;
            end
        end
    end
`else
    logic w_unused_rlast;
    assign w_unused_rlast = rlast;
`endif

endmodule

`default_nettype wire
